// File: rtl/sram_pkg.sv
// Shared definitions for the single-port SRAM responder and the BIST side that drives it.
// FSM encoding, default geometry and the BIST data patterns live here.
package sram_pkg;

   localparam int unsigned SRAM_DATA_W = 10;
   localparam int unsigned SRAM_ADDR_W = 8;
   localparam int unsigned SRAM_DEPTH  = 256;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } sram_state_e;

   localparam logic [SRAM_DATA_W-1:0] PAT_ONES  = 10'h3FF;
   localparam logic [SRAM_DATA_W-1:0] PAT_ZEROS = 10'h000;
   localparam logic [SRAM_DATA_W-1:0] PAT_ALT   = 10'h2AA;

endpackage

// File: rtl/sram_sp_array.sv
// Pure storage: one synchronous write port and one registered read port.
// Kept free of control logic so a foundry macro can replace it.
module sram_sp_array
   import sram_pkg::*;
#(
   parameter int unsigned DATA_W = SRAM_DATA_W,
   parameter int unsigned ADDR_W = SRAM_ADDR_W,
   parameter int unsigned DEPTH  = SRAM_DEPTH
) (
   input  logic              clock,
   input  logic              n_reset,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Array contents are deliberately not reset; the clear sweep initialises them.
   always_ff @(posedge clock) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_sp_responder.sv
// Single-port SRAM responder: clear sweep FSM, access counters, protocol-error flag.
// Define SRAM_FAULT_INJECT_EN to add stuck-at-on-read fault injection ports.
module sram_sp_responder
   import sram_pkg::*;
#(
   parameter int unsigned       DATA_W   = SRAM_DATA_W,
   parameter int unsigned       ADDR_W   = SRAM_ADDR_W,
   parameter int unsigned       DEPTH    = SRAM_DEPTH,
   parameter logic [DATA_W-1:0] INIT_VAL = '0,
   parameter int unsigned       CNT_W    = 16
) (
   input  logic              clock,
   input  logic              n_reset,
   input  logic              csn_i,
   input  logic              wen_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              clr_req_i,
`ifdef SRAM_FAULT_INJECT_EN
   input  logic              flt_en_i,
   input  logic [ADDR_W-1:0] flt_addr_i,
   input  logic [DATA_W-1:0] flt_mask_i,
   input  logic [DATA_W-1:0] flt_val_i,
`endif
   output logic [DATA_W-1:0] rd_data_o,
   output logic              init_busy_o,
   output logic              acc_err_o,
   output logic [CNT_W-1:0]  wr_cnt_o,
   output logic [CNT_W-1:0]  rd_cnt_o
);

   sram_state_e       state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              acc_err_q, acc_err_d;
   logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;

   logic              arr_we, arr_re;
   logic [ADDR_W-1:0] arr_waddr;
   logic [DATA_W-1:0] arr_wdata;
   logic [DATA_W-1:0] arr_rdata;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      acc_err_d = acc_err_q;
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      arr_we    = 1'b0;
      arr_re    = 1'b0;
      arr_waddr = addr_i;
      arr_wdata = wr_data_i;

      unique case (state_q)
         ST_INIT: begin
            arr_we    = 1'b1;
            arr_waddr = ptr_q;
            arr_wdata = INIT_VAL;
            if (!csn_i) begin
               acc_err_d = 1'b1;
            end
            if (ptr_q == ADDR_W'(DEPTH - 1)) begin
               state_d = ST_READY;
            end else begin
               ptr_d = ptr_q + ADDR_W'(1);
            end
         end
         ST_READY: begin
            arr_we = !csn_i && !wen_i;
            arr_re = !csn_i && wen_i;
            if (arr_we && wr_cnt_q != '1) begin
               wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end
            if (arr_re && rd_cnt_q != '1) begin
               rd_cnt_d = rd_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_INIT;
      endcase

      // A clear request overrides counter updates but not the access itself.
      if (clr_req_i) begin
         state_d   = ST_INIT;
         ptr_d     = '0;
         acc_err_d = 1'b0;
         wr_cnt_d  = '0;
         rd_cnt_d  = '0;
      end
   end

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state_q   <= ST_INIT;
         ptr_q     <= '0;
         acc_err_q <= 1'b0;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         acc_err_q <= acc_err_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
      end
   end

   sram_sp_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clock   (clock),
      .n_reset (n_reset),
      .we_i    (arr_we),
      .waddr_i (arr_waddr),
      .wdata_i (arr_wdata),
      .re_i    (arr_re),
      .raddr_i (addr_i),
      .rdata_o (arr_rdata)
   );

`ifdef SRAM_FAULT_INJECT_EN
   logic              flt_hit_q;
   logic [DATA_W-1:0] flt_mask_q, flt_val_q;

   // Fault controls are captured alongside the read so they line up with the registered data.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         flt_hit_q  <= 1'b0;
         flt_mask_q <= '0;
         flt_val_q  <= '0;
      end else if (arr_re) begin
         flt_hit_q  <= flt_en_i && (flt_addr_i == addr_i);
         flt_mask_q <= flt_mask_i;
         flt_val_q  <= flt_val_i;
      end
   end

   assign rd_data_o = flt_hit_q ? ((arr_rdata & ~flt_mask_q) | (flt_val_q & flt_mask_q))
                                : arr_rdata;
`else
   assign rd_data_o = arr_rdata;
`endif

   assign init_busy_o = (state_q == ST_INIT);
   assign acc_err_o   = acc_err_q;
   assign wr_cnt_o    = wr_cnt_q;
   assign rd_cnt_o    = rd_cnt_q;

endmodule
